// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, next-PC select encodings and fetch state enum
package riscv_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_ALU    = 2'b10;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    modport master (output imem_req_valid, imem_addr, input imem_req_ready, imem_rsp_valid, imem_rsp_data);
    modport slave  (input imem_req_valid, imem_addr, output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC select
module pc_next_mux
    import riscv_pkg::*;
(
    input  logic [1:0]  pcsrc,
    input  logic [31:0] pcplus4,
    input  logic [31:0] pctarget,
    input  logic [31:0] aluresult,
    output logic [31:0] pc_next
);
    assign pc_next = pcsrc == PCSRC_TARGET ? pctarget :
                     pcsrc == PCSRC_ALU    ? aluresult : pcplus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with held-instruction handshake
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic [31:0]  pc,
    output logic [31:0]  pcplus4,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic [1:0]   pcsrc,
    input  logic [31:0]  pctarget,
    input  logic [31:0]  aluresult,
    output logic         fault,
    output logic [31:0]  instret
);
    fetch_state_t state, next;
    logic [31:0] fetch_pc, pc_next;
    logic consume, misaligned;
    pc_next_mux u_mux (
        .pcsrc     (pcsrc),
        .pcplus4   (pcplus4),
        .pctarget  (pctarget),
        .aluresult (aluresult),
        .pc_next   (pc_next)
    );
    assign pcplus4             = pc + 32'd4;
    assign instr_valid         = state == S_HOLD;
    assign consume             = instr_valid & instr_ready;
    assign misaligned          = pc_next[1:0] != 2'b00;
    assign imem.imem_req_valid = state == S_REQ && !reset;
    assign imem.imem_addr      = fetch_pc;
    always_comb begin
        next = state;
        case (state)
            S_REQ:   next = imem.imem_req_ready ? S_WAIT : S_REQ;
            S_WAIT:  next = imem.imem_rsp_valid ? S_HOLD : S_WAIT;
            S_HOLD:  next = !instr_ready ? S_HOLD : misaligned ? S_FAULT : S_REQ;
            default: next = S_FAULT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            pc       <= RESET_PC;
            instr    <= INSTR_NOP;
            fault    <= 1'b0;
            instret  <= '0;
        end else begin
            state <= next;
            if (state == S_WAIT && imem.imem_rsp_valid) begin
                instr <= imem.imem_rsp_data;
                pc    <= fetch_pc;
            end
            // a misaligned target freezes fetch_pc so the faulting address stays visible
            if (consume) begin
                instret <= instret + 32'd1;
                if (misaligned) fault <= 1'b1;
                else fetch_pc <= pc_next;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a reference model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_ready = 1'b0;
    logic [1:0]  pcsrc = 2'b00;
    logic [31:0] pctarget = '0;
    logic [31:0] aluresult = '0;
    logic [31:0] instr, pc, pcplus4, instret;
    logic        instr_valid, fault;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] m_pc, m_instret, m_word;
    logic        m_fault;
    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .instr       (instr),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pcsrc       (pcsrc),
        .pctarget    (pctarget),
        .aluresult   (aluresult),
        .fault       (fault),
        .instret     (instret)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(negedge clk);
        #1;
    endtask
    task automatic do_reset;
        reset = 1'b1;
        instr_ready = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        tick;
        tick;
        check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_instret", instret, 32'd0);
        reset = 1'b0;
        m_pc = 32'h0;
        m_instret = 0;
        m_fault = 1'b0;
        m_word = 32'h0000_0013;
    endtask
    task automatic fetch_one(input int rd, input int hd, input logic [31:0] word);
        for (int i = 0; i < rd; i++) begin
            bus.imem_req_ready = 1'b0;
            #1;
            check("req_valid_stall", {31'd0, bus.imem_req_valid}, 32'd1);
            check("addr_stall", bus.imem_addr, m_pc);
            tick;
        end
        bus.imem_req_ready = 1'b1;
        #1;
        check("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("addr", bus.imem_addr, m_pc);
        check("iv_req", {31'd0, instr_valid}, 32'd0);
        tick;
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < hd; i++) begin
            bus.imem_rsp_valid = 1'b0;
            #1;
            check("no_second_req", {31'd0, bus.imem_req_valid}, 32'd0);
            check("iv_wait", {31'd0, instr_valid}, 32'd0);
            tick;
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = word;
        #1;
        check("iv_before_rsp", {31'd0, instr_valid}, 32'd0);
        tick;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = $urandom;
        m_word = word;
        #1;
        check("iv_hold", {31'd0, instr_valid}, 32'd1);
        check("instr", instr, m_word);
        check("pc", pc, m_pc);
        check("pcplus4", pcplus4, m_pc + 32'd4);
    endtask
    task automatic hold_noise(input int n);
        for (int i = 0; i < n; i++) begin
            instr_ready = 1'b0;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data = $urandom;
            tick;
        end
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("hold_instr", instr, m_word);
        check("hold_pc", pc, m_pc);
        check("hold_iv", {31'd0, instr_valid}, 32'd1);
    endtask
    task automatic consume(input logic [1:0] sel, input logic [31:0] tgt, input logic [31:0] alu);
        logic [31:0] nxt;
        instr_ready = 1'b1;
        pcsrc = sel;
        pctarget = tgt;
        aluresult = alu;
        tick;
        instr_ready = 1'b0;
        nxt = sel == 2'd1 ? tgt : sel == 2'd2 ? alu : m_pc + 32'd4;
        m_instret = m_instret + 1;
        if (nxt % 4 != 0) m_fault = 1'b1;
        else m_pc = nxt;
        #1;
        check("instret", instret, m_instret);
        check("fault", {31'd0, fault}, {31'd0, m_fault});
        check("iv_after_consume", {31'd0, instr_valid}, 32'd0);
        if (!m_fault) check("next_addr", bus.imem_addr, m_pc);
    endtask
    initial begin
        int c0;
        logic [31:0] r;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        // sequential fetches at full throughput
        do_reset;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            fetch_one(0, 0, 32'h0000_0013);
            consume(2'b00, 32'h0, 32'h0);
        end
        check("throughput_cycles", cyc - c0, 32'd9);
        check("addr_12", bus.imem_addr, 32'd12);
        // branch and jalr redirects
        do_reset;
        fetch_one(0, 0, 32'h0000_0013);
        consume(2'b00, 32'h0, 32'h0);
        fetch_one(0, 0, 32'h0000_0013);
        consume(2'b00, 32'h0, 32'h0);
        fetch_one(0, 0, 32'h0000_006f);
        consume(2'b01, 32'h40, 32'h0);
        check("addr_target", bus.imem_addr, 32'h40);
        fetch_one(0, 0, 32'h0000_0067);
        consume(2'b10, 32'h0, 32'h100);
        check("addr_alu", bus.imem_addr, 32'h100);
        // stalled request and slow response
        fetch_one(4, 3, 32'h00a0_0093);
        hold_noise(3);
        consume(2'b11, 32'h4, 32'h8);
        // randomized traffic with aligned redirects
        for (int i = 0; i < 25; i++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 1) == 1) hold_noise($urandom_range(1, 2));
            r = $urandom;
            consume(2'($urandom_range(0, 3)), {r[31:2], 2'b00}, {r[15:0], r[31:18], 2'b00});
        end
        // misaligned target traps
        fetch_one(0, 0, 32'h0000_006f);
        consume(2'b01, 32'h42, 32'h0);
        for (int i = 0; i < 5; i++) begin
            bus.imem_req_ready = 1'b1;
            bus.imem_rsp_valid = 1'b1;
            instr_ready = 1'b1;
            #1;
            check("fault_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
            check("fault_no_iv", {31'd0, instr_valid}, 32'd0);
            check("fault_sticky", {31'd0, fault}, 32'd1);
            tick;
        end
        // reset while waiting, late response must be dropped
        do_reset;
        bus.imem_req_ready = 1'b1;
        tick;
        bus.imem_req_ready = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = 32'hdead_beef;
        #1;
        check("late_rsp_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("late_rsp_addr", bus.imem_addr, 32'h0);
        tick;
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("late_rsp_instr", instr, 32'h0000_0013);
        check("late_rsp_iv", {31'd0, instr_valid}, 32'd0);
        fetch_one(0, 1, 32'h0050_0093);
        consume(2'b00, 32'h0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the address of the first fetch after reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req_valid  output  1  fetch request valid toward instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 imem_addr  output  32  fetch address; held stable while imem_req_valid=1.
REQ-007 imem_rsp_valid  input  1  memory returns the instruction word this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 instr  output  32  held instruction to the decoder; instr[6:0] is the op field.
REQ-010 pc  output  32  address of the held instruction.
REQ-011 pcplus4  output  32  pc+4, modulo 2^32.
REQ-012 instr_valid  output  1  instr/pc/pcplus4 are valid.
REQ-013 instr_ready  input  1  decode/execute consumes the held instruction this cycle.
REQ-014 pcsrc  input  2  next-PC select, sampled only on consume: 00 pcplus4, 01 pctarget, 10 aluresult, 11 pcplus4.
REQ-015 pctarget  input  32  branch/jal target.
REQ-016 aluresult  input  32  jalr target.
REQ-017 fault  output  1  sticky misaligned-fetch flag.
REQ-018 instret  output  32  count of consumed instructions.

Function
REQ-019 States: REQ, WAIT, HOLD, FAULT.
REQ-020 REQ: imem_req_valid=1, imem_addr=fetch_pc; on imem_req_ready=1, go to WAIT.
REQ-021 WAIT: imem_req_valid=0; on imem_rsp_valid=1, capture imem_rsp_data into instr, set pc=fetch_pc, go to HOLD.
REQ-022 HOLD: instr_valid=1 and instr, pc, pcplus4 stable until consumed; consume = instr_valid & instr_ready.
REQ-023 On consume: next fetch_pc is selected per pcsrc, instret increments by 1 (wraps at 2^32), and the state goes to REQ.
REQ-024 If the selected next PC has bits [1:0] != 00 at consume: fetch_pc is not updated, fault is set, and the state goes to FAULT.
REQ-025 FAULT: imem_req_valid=0 and instr_valid=0; left only by reset.
REQ-026 imem_rsp_valid in REQ, HOLD or FAULT is ignored and changes no state.
REQ-027 instr_valid=0 in REQ, WAIT and FAULT.
REQ-028 At most one request is outstanding at any time.
REQ-029 Throughput: with imem_req_ready=1, a 1-cycle response and instr_ready=1, one instruction is consumed every 3 cycles.
REQ-030 Latency: first request issued in the first cycle reset is low; with ready=1 and a next-cycle response, instr_valid is asserted 2 cycles later.
REQ-031 pcplus4 is combinational from pc; next-PC selection is combinational from pcsrc, pctarget, aluresult and pcplus4.

Reset
REQ-032 On reset=1 at a clock edge: state=REQ, fetch_pc=RESET_PC, pc=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, fault=0, instret=0.
REQ-033 While reset=1, imem_req_valid=0.
REQ-034 Reset mid-operation (WAIT or HOLD) discards the held or pending instruction; a response arriving after reset is ignored per REQ-026.

Structure
REQ-035 Shared package riscv_pkg holds the opcode constants, the pcsrc encodings (PCSRC_PLUS4, PCSRC_TARGET, PCSRC_ALU) and the fetch state enum.
REQ-036 One combinational sub-module, pc_next_mux, selects the next PC from pcsrc, pcplus4, pctarget and aluresult.

Verification
REQ-037 Reset, ready=1, 1-cycle response returning 32'h0000_0013 -> first imem_addr=0; instr_valid=1 two cycles later with pc=0, pcplus4=4.
REQ-038 Three sequential consumes with pcsrc=00 -> imem_addr sequence 0, 4, 8, 12; instret=3.
REQ-039 Consume at pc=8 with pcsrc=01, pctarget=32'h40 -> next imem_addr=32'h40; consume with pcsrc=10, aluresult=32'h100 -> next imem_addr=32'h100.
REQ-040 imem_req_ready low for 4 cycles, then response delayed 3 cycles -> imem_addr held stable, a single request issued, and instr_valid only after the response.
REQ-041 Consume with pcsrc=01, pctarget=32'h42 -> fault=1, FAULT state, no further requests until reset.
REQ-042 Reset asserted in WAIT with the response arriving the cycle after reset deasserts -> response ignored; fresh request issued at RESET_PC.
